// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/WAIT/VALID handshake between instruction memory and decode.
// Define FETCH_TIMEOUT_EN to build the WAIT-state timeout counter and FetchFault pulse.
module instr_fetch #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget,
  output logic [31:0] Instruction,
  output logic [10:0] OPCode,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  output logic        FetchFault
);

  typedef enum logic [1:0] {StIdle, StWait, StValid} state_e;

  localparam logic [63:0] PcAlignMask = ~64'd3;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [31:0] instr_q;
  logic [63:0] instr_pc_q;
  logic        valid_q;
  logic        req_q;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q;
  logic       fault_q;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC & PcAlignMask;
      instr_q    <= 32'h0;
      instr_pc_q <= 64'h0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= 8'h0;
      fault_q    <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          state_q <= StWait;
          req_q   <= 1'b1;
        end
        StWait: begin
          if (IMemAck) begin
            instr_q    <= IMemData;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= StValid;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= 8'h0;
`endif
          end else begin
`ifdef FETCH_TIMEOUT_EN
            // Request stays up at the same address; the fault is only a report.
            if (cnt_q + 8'd1 == TimeoutLimit) begin
              fault_q <= 1'b1;
              cnt_q   <= 8'h0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
`endif
          end
        end
        StValid: begin
          if (!Stall) begin
            pc_q    <= BranchTaken ? (BranchTarget & PcAlignMask) : pc_q + 64'd4;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= StWait;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMemReq     = req_q;
  assign IMemAddr    = pc_q;
  assign Instruction = instr_q;
  assign OPCode      = instr_q[31:21];
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = valid_q;

`ifdef FETCH_TIMEOUT_EN
  assign FetchFault = fault_q;
`else
  assign FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected fetches, a monitor checks them
// whenever InstrValid rises; directed checks cover reset, stall, branch, wrap and timeout.
module tb_instr_fetch;

  logic        CLOCK;
  logic        RESET_N;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic        Stall;
  logic        BranchTaken;
  logic [63:0] BranchTarget;
  logic [31:0] Instruction;
  logic [10:0] OPCode;
  logic [63:0] InstrPC;
  logic        InstrValid;
  logic        FetchFault;

  logic ack_en;
  logic force_ack;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t sb[$];
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic prev_valid = 1'b0;

  // Zero-wait memory: acks combinationally whenever a request is up and acking is enabled.
  assign IMemAck = force_ack | (IMemReq & ack_en);

  instr_fetch #(
    .RESET_PC      (64'h0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Instruction (Instruction),
    .OPCode      (OPCode),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .FetchFault  (FetchFault)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    fetch_t e;
    e.pc    = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  // Monitor: every new valid instruction must match the head of the scoreboard.
  always @(negedge CLOCK) begin
    if (RESET_N && InstrValid === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected no fetch", InstrPC, Instruction);
      end else begin
        fetch_t e;
        e = sb.pop_front();
        chk("mon_instr_pc", InstrPC, e.pc);
        chk("mon_instruction", {32'h0, Instruction}, {32'h0, e.instr});
        chk("mon_opcode", {53'h0, OPCode}, {53'h0, e.instr[31:21]});
      end
    end
    prev_valid <= (InstrValid === 1'b1);
  end

  localparam logic [31:0] D0 = 32'hF840_00A1;
  localparam logic [31:0] D1 = 32'h8B02_0020;
  localparam logic [31:0] D2 = 32'hB400_0041;
  localparam logic [31:0] D3 = 32'h1400_0003;
  localparam logic [31:0] D4 = 32'hD280_0020;
  localparam logic [31:0] D5 = 32'hAA01_03E2;
  localparam logic [31:0] D6 = 32'h9100_0421;

  initial begin
    RESET_N = 1'b1; ack_en = 1'b0; force_ack = 1'b0; IMemData = 32'h0;
    Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 64'h0;

    // Asynchronous reset, before any clock edge.
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_req", {63'h0, IMemReq}, 64'h0);
    chk("rst_valid", {63'h0, InstrValid}, 64'h0);
    chk("rst_addr", IMemAddr, 64'h0);
    chk("rst_instr", {32'h0, Instruction}, 64'h0);
    chk("rst_instr_pc", InstrPC, 64'h0);
    chk("rst_fault", {63'h0, FetchFault}, 64'h0);
    tick(); tick();

    // Sequential fetches at 0, 4, 8 with one instruction every second cycle.
    IMemData = D0; ack_en = 1'b1;
    push(64'h0, D0); push(64'h4, D0); push(64'h8, D0);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_req_hi", {63'h0, IMemReq}, 64'h1);
      chk("seq_addr", IMemAddr, 64'(i * 4));
      chk("seq_valid_lo", {63'h0, InstrValid}, 64'h0);
      tick();
      chk("seq_valid_hi", {63'h0, InstrValid}, 64'h1);
      chk("seq_req_lo", {63'h0, IMemReq}, 64'h0);
      chk("seq_opcode", {53'h0, OPCode}, 64'h7C2);
    end
    ack_en = 1'b0;
    tick();  // WAIT at 0xC, no ack
    tick();
    chk("noack_hold_valid", {63'h0, InstrValid}, 64'h0);
    chk("noack_hold_addr", IMemAddr, 64'hC);
    chk("noack_hold_instr", {32'h0, Instruction}, {32'h0, D0});

    // Branch taken from InstrPC 0x10 to 0x41 lands on 0x40.
    IMemData = D1; ack_en = 1'b1; push(64'hC, D1);
    tick();  // VALID 0xC
    tick();  // WAIT 0x10
    chk("br_pre_addr", IMemAddr, 64'h10);
    IMemData = D2; push(64'h10, D2);
    BranchTaken = 1'b1; BranchTarget = 64'h41;  // ignored while waiting
    tick();  // VALID 0x10
    chk("br_instr_pc", InstrPC, 64'h10);
    tick();
    chk("br_addr", IMemAddr, 64'h40);
    chk("br_req", {63'h0, IMemReq}, 64'h1);

    // Stall five cycles in VALID with BranchTaken toggling.
    BranchTaken = 1'b0; BranchTarget = 64'h100; Stall = 1'b1;
    IMemData = D3; push(64'h40, D3);
    tick();  // VALID 0x40 (stall has no effect in WAIT)
    for (int i = 0; i < 5; i++) begin
      BranchTaken = ~BranchTaken;
      tick();
      chk("stall_valid", {63'h0, InstrValid}, 64'h1);
      chk("stall_instr", {32'h0, Instruction}, {32'h0, D3});
      chk("stall_instr_pc", InstrPC, 64'h40);
      chk("stall_pc", IMemAddr, 64'h40);
      chk("stall_req", {63'h0, IMemReq}, 64'h0);
    end
    Stall = 1'b0; BranchTaken = 1'b0; ack_en = 1'b0;
    tick();
    chk("stall_release_addr", IMemAddr, 64'h44);
    chk("hold_instr_pc", InstrPC, 64'h40);
    chk("hold_instr", {32'h0, Instruction}, {32'h0, D3});

    // Branch to the top word, then PC+4 wraps to zero.
    IMemData = D4; ack_en = 1'b1; push(64'h44, D4);
    BranchTaken = 1'b1; BranchTarget = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();  // VALID 0x44
    tick();
    chk("top_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    BranchTaken = 1'b0; IMemData = D5; push(64'hFFFF_FFFF_FFFF_FFFC, D5);
    tick();
    tick();
    chk("wrap_addr", IMemAddr, 64'h0);
    ack_en = 1'b0;
    tick();

    // Reset mid-WAIT with ack held high: request abandoned, refetch from RESET_PC.
    IMemData = D6; force_ack = 1'b1; RESET_N = 1'b0;
    #1;
    chk("midrst_req", {63'h0, IMemReq}, 64'h0);
    tick(); tick();
    chk("midrst_valid", {63'h0, InstrValid}, 64'h0);
    chk("midrst_instr", {32'h0, Instruction}, 64'h0);
    push(64'h0, D6);
    RESET_N = 1'b1;
    tick();
    chk("refetch_idle_valid", {63'h0, InstrValid}, 64'h0);
    chk("refetch_addr", IMemAddr, 64'h0);
    chk("refetch_req", {63'h0, IMemReq}, 64'h1);
    tick();
    chk("refetch_valid", {63'h0, InstrValid}, 64'h1);
    force_ack = 1'b0;
    tick();  // consumed, now waiting at 0x4 with no ack

    // Long wait with no ack: fault pulses every 16 waiting cycles only when built in.
    for (int k = 1; k <= 40; k++) begin
      logic exp_fault;
`ifdef FETCH_TIMEOUT_EN
      exp_fault = (k == 16) || (k == 32);
`else
      exp_fault = 1'b0;
`endif
      tick();
      chk($sformatf("timeout_fault_%0d", k), {63'h0, FetchFault}, {63'h0, exp_fault});
      if (k % 8 == 0) begin
        chk("timeout_req", {63'h0, IMemReq}, 64'h1);
        chk("timeout_addr", IMemAddr, 64'h4);
      end
    end

    tick();
    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL sb_drain: got %0d pending fetches expected 0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
